instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Pipeline stage directly upstream of instruction_decode. Owns the PC and issues one word request at a time to instruction memory over a request/grant/response handshake. Buffers returned words and presents {instruction, pc, pc+4} to decode under a valid/ready handshake. Accepts a redirect (branch/jump target) from later stages and squashes wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
NOP_INSTR, 32'h0000_0000, value driven on out_instruction when no valid instruction is held

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
redirect  in  1  load redirect_pc as next fetch address, squash everything in flight
redirect_pc  in  32  redirect target; bits [1:0] forced to 0 internally
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch word address (byte address, 4-aligned)
imem_gnt  in  1  request accepted this cycle (meaningful only while imem_req=1)
imem_rvalid  in  1  response word valid; no backpressure, must be accepted
imem_rdata  in  32  response word
out_valid  out  1  instruction presented to decode
out_ready  in  1  decode accepts this cycle (decode stall = out_ready low)
out_instruction  out  32  fetched word
out_pc  out  32  address of out_instruction
out_pc_plus4  out  32  out_pc + 4, wraps modulo 2^32

Behaviour:
- Reset (async assert, sync release): state=S_IDLE, pc=RESET_PC, req_pc=0, discard=0, out_valid=0, out_instruction=NOP_INSTR, out_pc=0, out_pc_plus4=0, overflow buffer empty. imem_req=0 throughout reset.
- imem_req = (state==S_REQ); imem_addr = pc. Both combinational from registered state.
- At most one outstanding request. Responses arrive in order, at the earliest one cycle after gnt.
- S_IDLE -> S_REQ unconditionally on the first clock after reset release.
- S_REQ: on imem_gnt, latch req_pc=pc, pc<=pc+4 (wraps), go to S_WAIT.
- S_WAIT: on imem_rvalid with discard=0:
  - if the output register is empty or out_ready=1 this cycle, load output {rdata, req_pc, req_pc+4}, out_valid<=1, go to S_REQ;
  - otherwise write the word to the 1-entry overflow buffer and go to S_FULL.
- S_WAIT: on imem_rvalid with discard=1, drop the word, clear discard, go to S_REQ.
- S_FULL: imem_req=0. When out_ready=1, move the overflow entry into the output register and go to S_REQ.
- Output register: when out_valid=1 and out_ready=1 with no new load, out_valid<=0 and out_instruction<=NOP_INSTR. out_* are stable while out_valid=1 and out_ready=0.
- Peak throughput with zero-wait memory is 1 instruction per 2 cycles. Latency from gnt to out_valid is 2 cycles minimum.
- Redirect has highest priority and is evaluated the same cycle. Effects: pc<=redirect_pc&~3; out_valid<=0; output register reset to NOP_INSTR; overflow cleared. Next state by current state:
  - S_REQ without gnt: stay S_REQ; new address is driven next cycle.
  - S_REQ with gnt: the granted old-path request is outstanding, so go to S_WAIT with discard=1. pc is still set to the redirect target.
  - S_WAIT without rvalid: stay S_WAIT, set discard=1.
  - S_WAIT with rvalid: drop the word, go to S_REQ, discard stays 0.
  - S_FULL: go to S_REQ.
  - S_IDLE: pc is loaded, go to S_REQ.
- A redirect coincident with out_ready=1 is allowed; the presented word counts as consumed by decode.
- imem_gnt is ignored outside S_REQ. imem_rvalid is ignored outside S_WAIT; flag it as an assertion failure in simulation.
- PC arithmetic is 32-bit unsigned and wraps at 0xFFFF_FFFC -> 0x0000_0000.

Decomposition:
- Package if_pkg holds: state enum {S_IDLE, S_REQ, S_WAIT, S_FULL}, PC_STEP=4, NOP_INSTR default, fetch-bundle type {instr[31:0], pc[31:0]}.
- One natural sub-module, fetch_skid_buffer: output register plus 1-entry overflow, with valid/ready and a flush input. The FSM and PC stay in instruction_fetch.

Test Plan:
1. Hold rst_n=0, then release -> imem_req=0 during reset; in the second cycle after release imem_req=1, imem_addr=0x0; all out_* at reset values.
2. Zero-wait memory (gnt=1 in S_REQ, rvalid the next cycle), out_ready=1, mem[0x0]=0x20080005, mem[0x4]=0x20090003 -> out_valid pulses with (0x20080005, pc 0x0, pc+4 0x4) then (0x20090003, 0x4, 0x8), 2 cycles apart.
3. out_ready=0 for 6 cycles -> first word held stable, second word goes to overflow, state S_FULL, imem_req=0. On out_ready=1, words come out in order 0x0 then 0x4, no loss or duplication.
4. Redirect to 0x40 while in S_WAIT for 0x8, rvalid 3 cycles later -> stale word dropped, next imem_addr=0x40, first out_pc=0x40.
5. Redirect with redirect_pc=0x103 in the same cycle as imem_gnt for 0xC -> response for 0xC never reaches out_valid; next imem_addr=0x100.
6. Assert rst_n low mid S_WAIT, with rvalid arriving after release -> out_valid=0 immediately (async), the response is ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction fetch stage
package if_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FULL
  } if_state_e;

  localparam logic [31:0] PC_STEP           = 32'd4;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_bundle_t;

  // Fetch addresses are always word aligned; low byte-offset bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - decode-facing output register with a one-entry overflow
module fetch_skid_buffer
  import if_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  fetch_bundle_t in_data,
  output logic          in_direct,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [31:0]   out_instruction,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_pc_plus4
);

  fetch_bundle_t skid_data;
  logic          skid_valid;

  // A new word may go straight to the output when it is empty or being consumed.
  assign in_direct = !out_valid || out_ready;

  // Output register: flush first, then a fresh word, then the overflow refill, then drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      out_instruction <= NOP_INSTR;
      out_pc          <= '0;
      out_pc_plus4    <= '0;
    end else if (flush) begin
      out_valid       <= 1'b0;
      out_instruction <= NOP_INSTR;
    end else if (in_valid && in_direct) begin
      out_valid       <= 1'b1;
      out_instruction <= in_data.instr;
      out_pc          <= in_data.pc;
      out_pc_plus4    <= in_data.pc + PC_STEP;
    end else if (skid_valid && out_ready) begin
      out_valid       <= 1'b1;
      out_instruction <= skid_data.instr;
      out_pc          <= skid_data.pc;
      out_pc_plus4    <= skid_data.pc + PC_STEP;
    end else if (out_valid && out_ready) begin
      out_valid       <= 1'b0;
      out_instruction <= NOP_INSTR;
    end
  end

  // Overflow entry: catches a word that arrives while decode is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      skid_valid <= 1'b0;
    end else if (in_valid && !in_direct) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end else if (skid_valid && out_ready) begin
      skid_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC owner and single-outstanding instruction memory fetcher
module instruction_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
);

  if_state_e     state;
  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic          discard;
  logic          resp_keep;
  logic          in_direct;
  fetch_bundle_t resp_bundle;

  assign imem_req    = (state == S_REQ);
  assign imem_addr   = pc;
  assign resp_keep   = (state == S_WAIT) && imem_rvalid && !discard && !redirect;
  assign resp_bundle = '{instr: imem_rdata, pc: req_pc};

  // Fetch sequencer: advances the PC, tracks the one outstanding request, squashes wrong-path words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      req_pc  <= '0;
      discard <= 1'b0;
    end else if (redirect) begin
      pc <= align_word(redirect_pc);
      case (state)
        S_REQ: begin
          state   <= imem_gnt ? S_WAIT : S_REQ;
          discard <= imem_gnt;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state   <= S_REQ;
            discard <= 1'b0;
          end else begin
            discard <= 1'b1;
          end
        end
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (imem_gnt) begin
            req_pc <= pc;
            pc     <= pc + PC_STEP;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else begin
              state <= in_direct ? S_REQ : S_FULL;
            end
          end
        end
        S_FULL: begin
          if (out_ready) state <= S_REQ;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A response must match the single outstanding request; a straggler from before a reset may land while idle.
  assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (state == S_WAIT || state == S_IDLE));

  fetch_skid_buffer #(
    .NOP_INSTR(NOP_INSTR)
  ) u_skid (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (redirect),
    .in_valid       (resp_keep),
    .in_data        (resp_bundle),
    .in_direct      (in_direct),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_instruction(out_instruction),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instruction(out_instruction),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h2009_0003;
    return {~a[15:0], a[17:2]} ^ 32'h1357_9BDF;
  endfunction

  // Reference: a FIFO of words owed to decode (at most two), plus one outstanding-request flag.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } word_t;

  word_t       m_q[$];
  bit          m_started, m_out, m_disc;
  logic [31:0] m_pc, m_req_pc;

  function automatic bit m_req();
    return m_started && !m_out && (m_q.size() < 2);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_started = 0;
    m_out     = 0;
    m_disc    = 0;
    m_pc      = RPC;
    m_req_pc  = '0;
  endtask

  bit          mem_pending = 0;
  logic [31:0] mem_addr    = '0;
  logic [31:0] accepted[$];
  bit          saw_c = 0;
  string       phase = "init";

  task automatic check_outputs();
    chk($sformatf("%s.req", phase), imem_req, m_req());
    chk($sformatf("%s.addr", phase), imem_addr, m_pc);
    chk($sformatf("%s.valid", phase), out_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk($sformatf("%s.instr", phase), out_instruction, m_q[0].instr);
      chk($sformatf("%s.pc", phase), out_pc, m_q[0].pc);
      chk($sformatf("%s.pc4", phase), out_pc_plus4, m_q[0].pc + 32'd4);
    end else begin
      chk($sformatf("%s.nop", phase), out_instruction, NOP);
    end
  endtask

  // One clock: compare at the negedge, drive inputs, step model and memory, advance.
  task automatic run_cycle(input bit g, input bit rv, input bit rdy, input bit redir,
                           input logic [31:0] rpc);
    bit          granted, resp;
    logic [31:0] data;
    check_outputs();
    if (out_valid && rdy) accepted.push_back(out_pc);
    if (out_valid && out_pc == 32'hC) saw_c = 1;
    imem_gnt    = g;
    imem_rvalid = rv && mem_pending;
    data        = imem_rvalid ? mem_word(mem_addr) : $urandom;
    imem_rdata  = data;
    out_ready   = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    granted = m_req() && g;
    resp    = m_out && imem_rvalid;
    if (redir) begin
      m_q.delete();
      if (granted) begin
        m_out  = 1;
        m_disc = 1;
      end else if (m_out && !imem_rvalid) begin
        m_disc = 1;
      end else if (resp) begin
        m_out  = 0;
        m_disc = 0;
      end
      m_pc      = {rpc[31:2], 2'b00};
      m_started = 1;
    end else begin
      if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
      if (resp) begin
        if (m_disc) m_disc = 0;
        else m_q.push_back('{instr: data, pc: m_req_pc});
        m_out = 0;
      end
      if (granted) begin
        m_out    = 1;
        m_req_pc = m_pc;
        m_pc     = m_pc + 32'd4;
      end
      m_started = 1;
    end
    if (imem_rvalid) mem_pending = 0;
    if (imem_req && g) begin
      mem_pending = 1;
      mem_addr    = imem_addr;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic go_to_req();
    int n = 0;
    while (!m_req() && n < 20) begin
      run_cycle(0, 1, 1, 0, '0);
      n++;
    end
    chk("go_to_req.timeout", imem_req, 1'b1);
  endtask

  typedef struct {
    bit          g, rv, rdy;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_instr, exp_pc, exp_pc4;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          rd;
    logic [31:0] tgt;

    vecs[0] = '{1, 1, 1, 0, 32'h0, 0, NOP,           32'h0, 32'h0};
    vecs[1] = '{1, 1, 1, 1, 32'h0, 0, NOP,           32'h0, 32'h0};
    vecs[2] = '{1, 1, 1, 0, 32'h4, 0, NOP,           32'h0, 32'h0};
    vecs[3] = '{1, 1, 1, 1, 32'h4, 1, 32'h2008_0005, 32'h0, 32'h4};
    vecs[4] = '{1, 1, 1, 0, 32'h8, 0, NOP,           32'h0, 32'h0};
    vecs[5] = '{0, 1, 0, 1, 32'h8, 1, 32'h2009_0003, 32'h4, 32'h8};

    rst_n = 0; redirect = 0; redirect_pc = '0; imem_gnt = 0;
    imem_rvalid = 0; imem_rdata = '0; out_ready = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst.req", imem_req, 1'b0);
    chk("rst.valid", out_valid, 1'b0);
    chk("rst.instr", out_instruction, NOP);
    chk("rst.pc", out_pc, 32'h0);
    chk("rst.pc4", out_pc_plus4, 32'h0);
    rst_n = 1;

    phase = "zw";
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("vec%0d.req", i), imem_req, vecs[i].exp_req);
      chk($sformatf("vec%0d.addr", i), imem_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d.valid", i), out_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d.instr", i), out_instruction, vecs[i].exp_instr);
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d.pc", i), out_pc, vecs[i].exp_pc);
        chk($sformatf("vec%0d.pc4", i), out_pc_plus4, vecs[i].exp_pc4);
      end
      run_cycle(vecs[i].g, vecs[i].rv, vecs[i].rdy, 0, '0);
    end

    phase = "stall";
    run_cycle(0, 0, 0, 1, 32'h0);
    accepted.delete();
    for (int i = 0; i < 6; i++) run_cycle(1, 1, 0, 0, '0);
    chk("stall.req_off", imem_req, 1'b0);
    chk("stall.held_pc", out_pc, 32'h0);
    chk("stall.held_valid", out_valid, 1'b1);
    for (int i = 0; i < 3; i++) run_cycle(0, 1, 1, 0, '0);
    chk("stall.count", accepted.size(), 2);
    if (accepted.size() == 2) begin
      chk("stall.first", accepted[0], 32'h0);
      chk("stall.second", accepted[1], 32'h4);
    end

    phase = "redir_wait";
    run_cycle(1, 0, 1, 0, '0);
    run_cycle(0, 0, 1, 1, 32'h40);
    run_cycle(0, 0, 1, 0, '0);
    run_cycle(0, 0, 1, 0, '0);
    run_cycle(0, 1, 1, 0, '0);
    chk("redir_wait.req", imem_req, 1'b1);
    chk("redir_wait.addr", imem_addr, 32'h40);
    chk("redir_wait.valid", out_valid, 1'b0);
    run_cycle(1, 1, 1, 0, '0);
    run_cycle(1, 1, 1, 0, '0);
    chk("redir_wait.out_pc", out_pc, 32'h40);
    chk("redir_wait.out_instr", out_instruction, mem_word(32'h40));

    phase = "redir_gnt";
    go_to_req();
    run_cycle(0, 1, 1, 1, 32'hC);
    saw_c = 0;
    run_cycle(1, 0, 1, 1, 32'h103);
    run_cycle(0, 1, 1, 0, '0);
    chk("redir_gnt.req", imem_req, 1'b1);
    chk("redir_gnt.addr", imem_addr, 32'h100);
    run_cycle(1, 1, 1, 0, '0);
    run_cycle(1, 1, 1, 0, '0);
    chk("redir_gnt.out_pc", out_pc, 32'h100);
    chk("redir_gnt.out_pc4", out_pc_plus4, 32'h104);
    run_cycle(0, 1, 0, 0, '0);
    chk("redir_gnt.no_stale", saw_c, 1'b0);

    phase = "reset_mid";
    run_cycle(1, 0, 0, 0, '0);
    chk("reset_mid.pre_valid", out_valid, 1'b1);
    #2 rst_n = 0;
    #1;
    chk("reset_mid.valid", out_valid, 1'b0);
    chk("reset_mid.req", imem_req, 1'b0);
    chk("reset_mid.instr", out_instruction, NOP);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    run_cycle(0, 1, 1, 0, '0);
    chk("reset_mid.restart_req", imem_req, 1'b1);
    chk("reset_mid.restart_addr", imem_addr, RPC);
    run_cycle(1, 1, 1, 0, '0);
    run_cycle(1, 1, 1, 0, '0);
    chk("reset_mid.first_pc", out_pc, RPC);
    chk("reset_mid.first_instr", out_instruction, 32'h2008_0005);

    phase = "wrap";
    go_to_req();
    run_cycle(0, 1, 1, 1, 32'hFFFF_FFFF);
    run_cycle(1, 1, 1, 0, '0);
    chk("wrap.next_addr", imem_addr, 32'h0);
    run_cycle(0, 1, 1, 0, '0);
    chk("wrap.out_pc", out_pc, 32'hFFFF_FFFC);
    chk("wrap.out_pc4", out_pc_plus4, 32'h0);

    phase = "rand";
    for (int i = 0; i < 800; i++) begin
      rd  = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      run_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                $urandom_range(0, 9) < 6, rd, tgt);
    end
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
